sdram_port_arb: RTL

//  Shares one toggle-handshake SDRAM controller port (e.g. the ROM/BSRAM slot) between NCLIENT requesters.

---
 rtl/sdram_arb_pkg.sv | 14 +
 rtl/sdram_arb_rr_pick.sv | 48 ++++
 rtl/sdram_port_arb.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int NCLIENT_MAX = 8;
    // Wide enough for DATA_LAT up to 15
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// Combinational round-robin winner select from the pending vector and the last grant.
// SDRAM_ARB_FIXED_PRIO_EN: client 0 always wins when pending; the others rotate and only they move the pointer.
module sdram_arb_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NCLIENT = 3,
    parameter int IW      = 2
) (
    input  logic [NCLIENT-1:0] i_pend,
    input  logic [IW-1:0]      i_rr_last,
    output logic [IW-1:0]      o_win,
    output logic               o_vld,
    output logic               o_rr_upd
);

    logic [IW:0] w_idx;

    // Scan from furthest to nearest so the nearest pending client after i_rr_last is the final assignment
    always_comb begin
        o_vld = 1'b0;
        o_win = '0;
        w_idx = '0;
        for (int k = NCLIENT; k >= 1; k--) begin
            w_idx = {1'b0, i_rr_last} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(NCLIENT)) begin
                w_idx = w_idx - (IW+1)'(NCLIENT);
            end
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            if (i_pend[w_idx[IW-1:0]] && (w_idx != '0)) begin
`else
            if (i_pend[w_idx[IW-1:0]]) begin
`endif
                o_vld = 1'b1;
                o_win = w_idx[IW-1:0];
            end
        end
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        if (i_pend[0]) begin
            o_vld = 1'b1;
            o_win = '0;
        end
        o_rr_upd = (o_win != '0);
`else
        o_rr_upd = 1'b1;
`endif
    end

endmodule

// File: rtl/sdram_port_arb.sv
// Shares one toggle-handshake SDRAM port between NCLIENT clients (option: SDRAM_ARB_FIXED_PRIO_EN).
// Issue 1 clk after a pending request in IDLE; one transfer outstanding, later requests wait pending.
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int NCLIENT  = 3,
    parameter int AW       = 23,
    parameter int DW       = 16,
    parameter int DATA_LAT = 6,
    localparam int IW      = (NCLIENT > 1) ? $clog2(NCLIENT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCLIENT-1:0]    cl_req,
    output logic [NCLIENT-1:0]    cl_ack,
    input  logic [NCLIENT-1:0]    cl_we,
    input  logic [NCLIENT*AW-1:0] cl_addr,
    input  logic [NCLIENT*DW-1:0] cl_din,
    output logic [DW-1:0]         cl_dout,
    output logic [IW-1:0]         cl_grant,
    output logic                  mem_req,
    input  logic                  mem_req_ack,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_din,
    input  logic [DW-1:0]         mem_dout
);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [NCLIENT-1:0] r_cl_ack;
    logic [DW-1:0]      r_cl_dout;
    logic [IW-1:0]      r_grant;
    logic [IW-1:0]      r_rr_last;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [AW-1:0]      r_mem_addr;
    logic [DW-1:0]      r_mem_din;
    logic [LAT_W-1:0]   r_lat_cnt;

    logic [NCLIENT-1:0] w_pend;
    logic [NCLIENT-1:0] w_grant_oh;
    logic [IW-1:0]      w_win;
    logic               w_pick_vld;
    logic               w_rr_upd;
    logic               w_ack_in;
    logic               w_issue;
    logic               w_lat_load;
    logic               w_rd_done;
    logic               w_done;

    assign w_pend     = cl_req ^ r_cl_ack;
    assign w_grant_oh = NCLIENT'(1) << r_grant;
    assign w_ack_in   = (mem_req_ack == r_mem_req);

    sdram_arb_rr_pick #(.NCLIENT(NCLIENT), .IW(IW)) u_pick (
        .i_pend    (w_pend),
        .i_rr_last (r_rr_last),
        .o_win     (w_win),
        .o_vld     (w_pick_vld),
        .o_rr_upd  (w_rr_upd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_pick_vld) w_state_nxt = WAIT_ACK;
            WAIT_ACK:  if (w_ack_in) w_state_nxt = r_mem_we ? IDLE : WAIT_DATA;
            WAIT_DATA: if (r_lat_cnt == '0) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // The controller acks at CAS, so reads still wait DATA_LAT clocks for mem_dout
    always_comb begin
        w_issue    = 1'b0;
        w_lat_load = 1'b0;
        w_rd_done  = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE:      w_issue = w_pick_vld;
            WAIT_ACK: begin
                if (w_ack_in) begin
                    w_done     = r_mem_we;
                    w_lat_load = ~r_mem_we;
                end
            end
            WAIT_DATA: begin
                if (r_lat_cnt == '0) begin
                    w_done    = 1'b1;
                    w_rd_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_req  <= mem_req_ack;
            r_cl_ack   <= cl_req;
            r_cl_dout  <= '0;
            r_grant    <= '0;
            r_rr_last  <= IW'(NCLIENT - 1);
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_lat_cnt  <= '0;
        end else begin
            if (w_issue) begin
                r_mem_req  <= ~r_mem_req;
                r_grant    <= w_win;
                r_mem_we   <= cl_we[w_win];
                r_mem_addr <= cl_addr[w_win*AW +: AW];
                r_mem_din  <= cl_din[w_win*DW +: DW];
                if (w_rr_upd) r_rr_last <= w_win;
            end
            if (w_lat_load) begin
                r_lat_cnt <= LAT_W'(DATA_LAT - 1);
            end else if ((r_state == WAIT_DATA) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end
            if (w_rd_done) r_cl_dout <= mem_dout;
            if (w_done)    r_cl_ack  <= r_cl_ack ^ w_grant_oh;
        end
    end

    assign cl_ack   = r_cl_ack;
    assign cl_dout  = r_cl_dout;
    assign cl_grant = r_grant;
    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;

endmodule
